// File: rtl/local_predictor_spec.sv
// local_predictor_spec
// Two-level local branch predictor for the fetch stage. Each local history
// table (LHT) entry holds the recent outcomes of the branches that map to it.
// That history selects a saturating counter in the pattern history table (PHT).
// After reset a sweep clears both tables, one entry per cycle.
//
// Optional feature macro: LOCAL_PRED_BYPASS_EN
//   When defined, a lookup in the same cycle as an update sees the post-update
//   counter and any same-index LHT repair.
//   When undefined, a lookup sees table state as of the previous edge.
//
// Ports
//   clk, reset       clock (rising edge), synchronous active-high reset
//   ready            init sweep finished; lookups and updates are accepted
//   lookup_valid     look up a prediction for pc_bits_read
//   pred_valid       prediction/history_out valid (one cycle after lookup)
//   prediction       1 = predicted taken
//   history_out      pre-shift history used for this prediction
//   update_valid     resolved branch update at pc_bits_write
//   history_write    history_out value carried back with the branch
//   outcome          resolved direction, 1 = taken
//   mispredict       qualifies update_valid; repairs the LHT entry
//
// state | meaning
// INIT  | sweeping sweep_ptr over both tables; requests ignored
// RUN   | tables valid; ready asserts on the first RUN cycle edge
module local_predictor_spec #(
  parameter int HISTORY_LEN    = 10,
  parameter int LHT_INDEX_BITS = 7,
  parameter int CTR_BITS       = 2,
  parameter int PC_LSB         = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ready,
  input  logic                   lookup_valid,
  input  logic [15:0]            pc_bits_read,
  output logic                   pred_valid,
  output logic                   prediction,
  output logic [HISTORY_LEN-1:0] history_out,
  input  logic                   update_valid,
  input  logic [15:0]            pc_bits_write,
  input  logic [HISTORY_LEN-1:0] history_write,
  input  logic                   outcome,
  input  logic                   mispredict
);

  localparam int LHT_DEPTH = 1 << LHT_INDEX_BITS;
  localparam int PHT_DEPTH = 1 << HISTORY_LEN;
  localparam int PTR_BITS  = (HISTORY_LEN > LHT_INDEX_BITS) ? HISTORY_LEN : LHT_INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [PTR_BITS-1:0]   sweep_ptr;
  logic [HISTORY_LEN-1:0] lht [LHT_DEPTH];
  logic [CTR_BITS-1:0]   pht [PHT_DEPTH];

  logic                      do_lookup, do_update, do_repair;
  logic [LHT_INDEX_BITS-1:0] idx_rd, idx_wr;
  logic [HISTORY_LEN-1:0]    hist_rd, repair_hist, spec_hist;
  logic [CTR_BITS-1:0]       ctr_rd, ctr_upd_old, ctr_upd_new;
  logic                      sweep_lht_en, sweep_pht_en, sweep_last;
  logic                      unused_pc_bits;

  // ready is only ever set in RUN, so it alone gates requests
  assign do_lookup = ready & lookup_valid;
  assign do_update = ready & update_valid;
  assign do_repair = do_update & mispredict;

  // upper PC bits alias onto the same LHT entry
  assign idx_rd         = pc_bits_read[PC_LSB +: LHT_INDEX_BITS];
  assign idx_wr         = pc_bits_write[PC_LSB +: LHT_INDEX_BITS];
  assign unused_pc_bits = ^{pc_bits_read, pc_bits_write};

  assign repair_hist = {history_write[HISTORY_LEN-2:0], outcome};
  assign ctr_upd_old = pht[history_write];

  always_comb begin
    ctr_upd_new = ctr_upd_old;
    if (outcome) begin
      if (ctr_upd_old != CTR_MAX) ctr_upd_new = ctr_upd_old + CTR_BITS'(1);
    end else begin
      if (ctr_upd_old != '0) ctr_upd_new = ctr_upd_old - CTR_BITS'(1);
    end
  end

`ifdef LOCAL_PRED_BYPASS_EN
  always_comb begin
    hist_rd = lht[idx_rd];
    if (do_repair && (idx_wr == idx_rd)) hist_rd = repair_hist;
    ctr_rd = pht[hist_rd];
    if (do_update && (history_write == hist_rd)) ctr_rd = ctr_upd_new;
  end
`else
  assign hist_rd = lht[idx_rd];
  assign ctr_rd  = pht[hist_rd];
`endif

  assign spec_hist = {hist_rd[HISTORY_LEN-2:0], ctr_rd[CTR_BITS-1]};

  // the sweep covers the deeper of the two tables; the shallower is guarded
  assign sweep_lht_en = ({1'b0, sweep_ptr} < (PTR_BITS+1)'(LHT_DEPTH));
  assign sweep_pht_en = ({1'b0, sweep_ptr} < (PTR_BITS+1)'(PHT_DEPTH));
  assign sweep_last   = &sweep_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      sweep_ptr   <= '0;
      ready       <= 1'b0;
      pred_valid  <= 1'b0;
      prediction  <= 1'b0;
      history_out <= '0;
    end else begin
      case (state)
        INIT: begin
          ready     <= 1'b0;
          sweep_ptr <= sweep_ptr + PTR_BITS'(1);
          if (sweep_last) state <= RUN;
        end
        default: ready <= 1'b1;
      endcase
      pred_valid <= do_lookup;
      if (do_lookup) begin
        prediction  <= ctr_rd[CTR_BITS-1];
        history_out <= hist_rd;
      end
    end
  end

  // Table storage is not reset; the sweep initialises it. The repair write
  // comes after the speculative shift so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        if (sweep_lht_en) lht[sweep_ptr[LHT_INDEX_BITS-1:0]] <= '0;
        if (sweep_pht_en) pht[sweep_ptr[HISTORY_LEN-1:0]] <= CTR_WEAK_NT;
      end else begin
        if (do_lookup) lht[idx_rd] <= spec_hist;
        if (do_repair) lht[idx_wr] <= repair_hist;
        if (do_update) pht[history_write] <= ctr_upd_new;
      end
    end
  end

endmodule

// File: tb/tb_local_predictor_spec.sv
// Testbench for local_predictor_spec (default parameters).
module tb_local_predictor_spec;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        lookup_valid;
  logic [15:0] pc_bits_read;
  logic        pred_valid;
  logic        prediction;
  logic [9:0]  history_out;
  logic        update_valid;
  logic [15:0] pc_bits_write;
  logic [9:0]  history_write;
  logic        outcome;
  logic        mispredict;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  local_predictor_spec dut (
    .clk(clk), .reset(reset), .ready(ready),
    .lookup_valid(lookup_valid), .pc_bits_read(pc_bits_read),
    .pred_valid(pred_valid), .prediction(prediction), .history_out(history_out),
    .update_valid(update_valid), .pc_bits_write(pc_bits_write),
    .history_write(history_write), .outcome(outcome), .mispredict(mispredict)
  );

  // reference model: tables as plain integer arrays
  int lht_m [128];
  int pht_m [1024];
  int exp_pv, exp_pred, exp_hist;

  function automatic int idx_of(input logic [15:0] pc);
    return (int'(pc) / 4) % 128;
  endfunction

  function automatic int sat(input int v);
    if (v > 3) return 3;
    if (v < 0) return 0;
    return v;
  endfunction

  function automatic void model_init();
    for (int i = 0; i < 128; i++) lht_m[i] = 0;
    for (int i = 0; i < 1024; i++) pht_m[i] = 1;
    exp_pv = 0; exp_pred = 0; exp_hist = 0;
  endfunction

  function automatic void model_step(input bit lv, input logic [15:0] pcr, input bit uv,
                                     input logic [15:0] pcw, input int hw, input bit oc,
                                     input bit mp);
    int h, c, upd;
    upd = sat(pht_m[hw] + (oc ? 1 : -1));
    if (lv) begin
      h = lht_m[idx_of(pcr)];
`ifdef LOCAL_PRED_BYPASS_EN
      if (uv && mp && idx_of(pcw) == idx_of(pcr)) h = (hw * 2 + int'(oc)) % 1024;
      c = (uv && hw == h) ? upd : pht_m[h];
`else
      c = pht_m[h];
`endif
      exp_pv = 1; exp_pred = (c >= 2) ? 1 : 0; exp_hist = h;
      lht_m[idx_of(pcr)] = (h * 2 + exp_pred) % 1024;
    end else begin
      exp_pv = 0;
    end
    if (uv) begin
      pht_m[hw] = upd;
      if (mp) lht_m[idx_of(pcw)] = (hw * 2 + int'(oc)) % 1024;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int pv, input int pr, input int hi);
    chk(name, {20'd0, pred_valid, prediction, history_out},
        32'((pv << 11) | (pr << 10) | hi));
  endtask

  task automatic run_cycle(input bit lv, input logic [15:0] pcr, input bit uv,
                           input logic [15:0] pcw, input logic [9:0] hw, input bit oc,
                           input bit mp);
    lookup_valid = lv; pc_bits_read = pcr; update_valid = uv;
    pc_bits_write = pcw; history_write = hw; outcome = oc; mispredict = mp;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    lookup_valid = 0; update_valid = 0; mispredict = 0; outcome = 0;
    pc_bits_read = 0; pc_bits_write = 0; history_write = 0;
  endtask

  // reset held for one edge with busy inputs; all outputs must be cleared
  task automatic reset_pulse(input string name);
    reset = 1; lookup_valid = 1; update_valid = 1; mispredict = 1; outcome = 1;
    pc_bits_read = 16'h0010; pc_bits_write = 16'h0010; history_write = 10'h3ff;
    @(posedge clk); #1;
    chk({name, "_outputs"}, {28'd0, ready, pred_valid, prediction, |history_out}, 32'd0);
    reset = 0;
  endtask

  // counts edges after reset falls until ready; requests stay active throughout
  task automatic count_init(input string name);
    int  n;
    bit  saw_pv;
    n = 0; saw_pv = 0;
    while (n < 1100) begin
      lookup_valid = 1; update_valid = 1; mispredict = 1;
      outcome = 1'($urandom); pc_bits_read = 16'($urandom); pc_bits_write = 16'($urandom);
      history_write = 10'($urandom);
      @(posedge clk); #1;
      n++;
      if (pred_valid) saw_pv = 1;
      if (ready) break;
    end
    idle_inputs();
    chk({name, "_ready_cycles"}, n, 1025);
    chk({name, "_pv_in_init"}, {31'd0, saw_pv}, 0);
  endtask

  typedef struct {
    bit          lv;
    logic [15:0] pcr;
    bit          uv;
    logic [15:0] pcw;
    logic [9:0]  hw;
    bit          oc;
    bit          mp;
    int          pv;
    int          pr;
    int          hi;
  } vec_t;

  vec_t tv [25];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;

    // directed vectors, starting from freshly initialised tables
    //            lv  pcr       uv  pcw      hw     oc mp  pv pr hi
    tv[0]  = '{1, 16'h0004, 0, 16'h0000, 10'd0,  0, 0, 1, 0, 0};
    tv[1]  = '{1, 16'h0008, 0, 16'h0000, 10'd0,  0, 0, 1, 0, 0};
    tv[2]  = '{1, 16'h0008, 0, 16'h0000, 10'd0,  0, 0, 1, 0, 0};
    tv[3]  = '{0, 16'h0000, 1, 16'h0008, 10'd0,  1, 1, 0, 0, 0};
    tv[4]  = '{1, 16'h0008, 0, 16'h0000, 10'd0,  0, 0, 1, 0, 1};
    tv[5]  = '{0, 16'h0000, 1, 16'h0004, 10'd0,  1, 0, 0, 0, 1};
    tv[6]  = '{0, 16'h0000, 1, 16'h0004, 10'd0,  1, 0, 0, 0, 1};
    tv[7]  = '{1, 16'h0004, 0, 16'h0000, 10'd0,  0, 0, 1, 1, 0};
`ifdef LOCAL_PRED_BYPASS_EN
    tv[8]  = '{1, 16'h0008, 1, 16'h0008, 10'd3,  1, 1, 1, 0, 7};
`else
    tv[8]  = '{1, 16'h0008, 1, 16'h0008, 10'd3,  1, 1, 1, 0, 2};
`endif
    tv[9]  = '{1, 16'h0008, 0, 16'h0000, 10'd0,  0, 0, 1, 0, 7};
    tv[10] = '{1, 16'h0208, 0, 16'h0000, 10'd0,  0, 0, 1, 0, 14};
    tv[11] = '{0, 16'h0000, 1, 16'h0000, 10'd28, 1, 0, 0, 0, 14};
    tv[12] = '{1, 16'h0208, 0, 16'h0000, 10'd0,  0, 0, 1, 1, 28};
    tv[13] = '{0, 16'h0000, 1, 16'h0000, 10'd28, 0, 0, 0, 1, 28};
    tv[14] = '{0, 16'h0000, 1, 16'h0000, 10'd28, 0, 0, 0, 1, 28};
    tv[15] = '{0, 16'h0000, 1, 16'h0000, 10'd28, 0, 0, 0, 1, 28};
    tv[16] = '{0, 16'h0000, 1, 16'h000c, 10'd14, 0, 1, 0, 1, 28};
    tv[17] = '{1, 16'h000c, 0, 16'h0000, 10'd0,  0, 0, 1, 0, 28};
    tv[18] = '{0, 16'h0000, 1, 16'h0000, 10'd28, 1, 0, 0, 0, 28};
    tv[19] = '{0, 16'h0000, 1, 16'h000c, 10'd14, 0, 1, 0, 0, 28};
    tv[20] = '{1, 16'h000c, 0, 16'h0000, 10'd0,  0, 0, 1, 0, 28};
    tv[21] = '{1, 16'h0010, 0, 16'h000c, 10'h3ff, 1, 1, 1, 1, 0};
    tv[22] = '{1, 16'h000c, 0, 16'h0000, 10'd0,  0, 0, 1, 0, 56};
    tv[23] = '{0, 16'h0000, 1, 16'h0004, 10'd0,  1, 0, 0, 0, 56};
    tv[24] = '{1, 16'h0014, 0, 16'h0000, 10'd0,  0, 0, 1, 1, 0};

    // init sweep length, with requests held active during INIT
    reset_pulse("reset1");
    count_init("init1");

    for (int i = 0; i < 25; i++) begin
      run_cycle(tv[i].lv, tv[i].pcr, tv[i].uv, tv[i].pcw, tv[i].hw, tv[i].oc, tv[i].mp);
      chk_out($sformatf("vec%0d", i), tv[i].pv, tv[i].pr, tv[i].hi);
    end

    // reset during a lookup clears outputs, then reset mid-sweep restarts init
    run_cycle(1, 16'h000c, 0, 16'h0000, 10'd0, 0, 0);
    chk_out("pre_abort", 1, 0, 112);
    reset_pulse("abort_lookup");
    repeat (500) begin
      lookup_valid = 1; pc_bits_read = 16'($urandom);
      @(posedge clk); #1;
      chk("midsweep_pv", {31'd0, pred_valid}, 0);
    end
    reset_pulse("abort_sweep");
    count_init("init2");

    // randomized traffic against the model
    model_init();
    for (int i = 0; i < 3000; i++) begin
      bit          lv, uv, oc, mp;
      logic [15:0] pcr, pcw;
      int          hw;
      lv  = 1'($urandom);
      uv  = 1'($urandom);
      oc  = 1'($urandom);
      mp  = ($urandom_range(0, 3) == 0);
      pcr = 16'(($urandom_range(0, 7) * 4) + ($urandom_range(0, 3) * 512));
      pcw = 16'(($urandom_range(0, 7) * 4) + ($urandom_range(0, 3) * 512));
      hw  = ($urandom_range(0, 1) == 0) ? lht_m[$urandom_range(0, 7)] : $urandom_range(0, 7);
      run_cycle(lv, pcr, uv, pcw, 10'(hw), oc, mp);
      model_step(lv, pcr, uv, pcw, hw, oc, mp);
      chk_out($sformatf("rand%0d", i), exp_pv, exp_pred, exp_hist);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
